// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - Clause 22 MDIO PHY-side responder with indirect extended registers
//
// Purpose:
//    Oversamples MDC/MDIO on clk_eth_i and decodes Clause 22 write and read frames
//    addressed to PHY_ADDR. Read data goes back on the MDIO tristate. Extended
//    registers are reached through REGCR (0x0D) / ADDAR (0x0E). Three of them are
//    implemented and exported.
//
// Ports:
//    clk_eth_i        Ethernet clock, all logic on rising edge
//    rst_eth_i        synchronous active-high reset
//    mdio_mdc_i       MDC from the master (asynchronous)
//    mdio_mdio_i      MDIO pad input
//    mdio_mdio_o      MDIO drive value
//    mdio_mdio_t      MDIO tristate enable (1 = released, 0 = driving)
//    busy_o           frame decode in progress
//    ext_wr_o         one-cycle pulse on every extended-register write
//    ext_addr_o       extended address of the last extended write
//    cfg4_o           extended register 0x0031
//    sgmiictl1_o      extended register 0x00D3
//    sgmii_10m_cfg_o  extended register 0x016F

module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR = 5'h03,
   parameter logic [15:0] PHY_ID1  = 16'h2000,
   parameter logic [15:0] PHY_ID2  = 16'hA231,
   parameter int          PRE_LEN  = 32
) (
   input  logic        clk_eth_i,
   input  logic        rst_eth_i,
   input  logic        mdio_mdc_i,
   input  logic        mdio_mdio_i,
   output logic        mdio_mdio_o,
   output logic        mdio_mdio_t,
   output logic        busy_o,
   output logic        ext_wr_o,
   output logic [15:0] ext_addr_o,
   output logic [15:0] cfg4_o,
   output logic [15:0] sgmiictl1_o,
   output logic [15:0] sgmii_10m_cfg_o
);

   localparam logic [5:0]  PRE_MAX    = 6'(PRE_LEN);
   localparam logic [15:0] EXT_CFG4   = 16'h0031;
   localparam logic [15:0] EXT_SGCTL1 = 16'h00D3;
   localparam logic [15:0] EXT_SG10M  = 16'h016F;

   typedef enum logic [2:0] {
      S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
   } state_t;

   state_t state, state_nxt;

   // Synchronizers and MDC edge detection
   logic mdc_s1, mdc_s2, mdc_d;
   logic mdio_s1, mdio_s2;
   logic mdc_rise, mdc_fall, bit_in;

   assign mdc_rise = mdc_s2 & ~mdc_d;
   assign mdc_fall = ~mdc_s2 & mdc_d;
   assign bit_in   = mdio_s2;

   // Frame decode state
   logic [5:0]  pre_cnt;
   logic [4:0]  bit_cnt;
   logic        op_hi;
   logic        op_rd;
   logic [4:0]  phyad;
   logic [4:0]  regad;
   logic [4:0]  regad_full;
   logic [15:0] wdata;
   logic [15:0] rdata_sh;
   logic        wr_commit;

   // Output drive registers and their next values
   logic drv_o, drv_t;
   logic drv_o_nxt, drv_t_nxt;

   // Register storage
   logic [15:0] regfile [32];
   logic [15:0] ext_addr_lat;
   logic [15:0] cfg4, sgctl1, sg10m;
   logic        ext_wr;
   logic [15:0] ext_addr_q;
   logic [1:0]  regcr_fn;
   logic [4:0]  regcr_devad;
   logic [15:0] ext_rd;
   logic [15:0] rd_val;

   assign regcr_fn    = regfile[5'h0D][15:14];
   assign regcr_devad = regfile[5'h0D][4:0];

   // The last REGAD bit is still in flight when the read word is latched
   assign regad_full = {regad[3:0], bit_in};

   always_comb begin
      ext_rd = 16'h0000;
      case (ext_addr_lat)
         EXT_CFG4:   ext_rd = cfg4;
         EXT_SGCTL1: ext_rd = sgctl1;
         EXT_SG10M:  ext_rd = sg10m;
         default:    ext_rd = 16'h0000;
      endcase
   end

   always_comb begin
      rd_val = 16'h0000;
      case (regad_full)
         5'h02:   rd_val = PHY_ID1;
         5'h03:   rd_val = PHY_ID2;
         5'h0E: begin
            if (regcr_fn == 2'b00)
               rd_val = ext_addr_lat;
            else if (regcr_devad == 5'h1F)
               rd_val = ext_rd;
            else
               rd_val = 16'h0000;
         end
         default: rd_val = regfile[regad_full];
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk_eth_i) begin
      if (rst_eth_i)
         state <= S_PRE;
      else
         state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_PRE: begin
            if (mdc_rise && !bit_in && pre_cnt == PRE_MAX)
               state_nxt = S_ST;
         end
         S_ST: begin
            if (mdc_rise)
               state_nxt = bit_in ? S_OP : S_PRE;
         end
         S_OP: begin
            // 01 and 10 are the only legal opcodes, i.e. the two bits differ
            if (mdc_rise && bit_cnt == 5'd1)
               state_nxt = (op_hi != bit_in) ? S_PHYAD : S_PRE;
         end
         S_PHYAD: begin
            if (mdc_rise && bit_cnt == 5'd4)
               state_nxt = S_REGAD;
         end
         S_REGAD: begin
            // Foreign frames are dropped here, before any turnaround drive
            if (mdc_rise && bit_cnt == 5'd4)
               state_nxt = (phyad == PHY_ADDR) ? S_TA : S_PRE;
         end
         S_TA: begin
            if (mdc_rise && bit_cnt == 5'd1)
               state_nxt = op_rd ? S_RDATA : S_WDATA;
         end
         S_WDATA: begin
            if (mdc_rise && bit_cnt == 5'd15)
               state_nxt = S_PRE;
         end
         S_RDATA: begin
            if (mdc_fall && bit_cnt == 5'd16)
               state_nxt = S_PRE;
         end
         default: state_nxt = S_PRE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_o    = (state != S_PRE);
      drv_o_nxt = drv_o;
      drv_t_nxt = drv_t;
      case (state)
         S_TA: begin
            // Second turnaround bit is driven low by the PHY on reads
            if (mdc_fall && op_rd && bit_cnt == 5'd1) begin
               drv_t_nxt = 1'b0;
               drv_o_nxt = 1'b0;
            end
         end
         S_RDATA: begin
            if (mdc_fall) begin
               if (bit_cnt == 5'd16) begin
                  drv_t_nxt = 1'b1;
                  drv_o_nxt = 1'b1;
               end else begin
                  drv_o_nxt = rdata_sh[15];
               end
            end
         end
         default: begin
            drv_t_nxt = 1'b1;
            drv_o_nxt = 1'b1;
         end
      endcase
   end

   // Datapath
   always_ff @(posedge clk_eth_i) begin
      if (rst_eth_i) begin
         mdc_s1       <= 1'b0;
         mdc_s2       <= 1'b0;
         mdc_d        <= 1'b0;
         mdio_s1      <= 1'b1;
         mdio_s2      <= 1'b1;
         pre_cnt      <= 6'd0;
         bit_cnt      <= 5'd0;
         op_hi        <= 1'b0;
         op_rd        <= 1'b0;
         phyad        <= 5'd0;
         regad        <= 5'd0;
         wdata        <= 16'h0000;
         rdata_sh     <= 16'h0000;
         wr_commit    <= 1'b0;
         drv_o        <= 1'b1;
         drv_t        <= 1'b1;
         ext_wr       <= 1'b0;
         ext_addr_q   <= 16'h0000;
         ext_addr_lat <= 16'h0000;
         cfg4         <= 16'h0000;
         sgctl1       <= 16'h0000;
         sg10m        <= 16'h0000;
         for (int i = 0; i < 32; i++)
            regfile[i] <= 16'h0000;
      end else begin
         mdc_s1    <= mdio_mdc_i;
         mdc_s2    <= mdc_s1;
         mdc_d     <= mdc_s2;
         mdio_s1   <= mdio_mdio_i;
         mdio_s2   <= mdio_s1;
         drv_o     <= drv_o_nxt;
         drv_t     <= drv_t_nxt;
         wr_commit <= 1'b0;
         ext_wr    <= 1'b0;

         if (state_nxt != state)
            bit_cnt <= 5'd0;
         else if (mdc_rise && state != S_PRE)
            bit_cnt <= bit_cnt + 5'd1;

         if (mdc_rise) begin
            case (state)
               S_PRE: begin
                  if (!bit_in)
                     pre_cnt <= 6'd0;
                  else if (pre_cnt != PRE_MAX)
                     pre_cnt <= pre_cnt + 6'd1;
               end
               S_OP: begin
                  if (bit_cnt == 5'd0)
                     op_hi <= bit_in;
                  else
                     op_rd <= op_hi;
               end
               S_PHYAD: phyad <= {phyad[3:0], bit_in};
               S_REGAD: begin
                  regad <= regad_full;
                  if (bit_cnt == 5'd4)
                     rdata_sh <= rd_val;
               end
               S_WDATA: begin
                  wdata <= {wdata[14:0], bit_in};
                  if (bit_cnt == 5'd15)
                     wr_commit <= 1'b1;
               end
               default: ;
            endcase
         end

         if (mdc_fall && state == S_RDATA && bit_cnt != 5'd16)
            rdata_sh <= {rdata_sh[14:0], 1'b0};

         // Commit one cycle after the last data rise, once wdata holds the full word
         if (wr_commit) begin
            case (regad)
               5'h02, 5'h03: ;
               5'h0E: begin
                  if (regcr_fn == 2'b00) begin
                     ext_addr_lat <= wdata;
                  end else if (regcr_devad == 5'h1F) begin
                     ext_wr     <= 1'b1;
                     ext_addr_q <= ext_addr_lat;
                     case (ext_addr_lat)
                        EXT_CFG4:   cfg4   <= wdata;
                        EXT_SGCTL1: sgctl1 <= wdata;
                        EXT_SG10M:  sg10m  <= wdata;
                        default: ;
                     endcase
                  end
               end
               default: regfile[regad] <= wdata;
            endcase
         end
      end
   end

   assign mdio_mdio_o     = drv_o;
   assign mdio_mdio_t     = drv_t;
   assign ext_wr_o        = ext_wr;
   assign ext_addr_o      = ext_addr_q;
   assign cfg4_o          = cfg4;
   assign sgmiictl1_o     = sgctl1;
   assign sgmii_10m_cfg_o = sg10m;

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

Synthesizable MDIO target (PHY-side responder) for IEEE 802.3 Clause 22 management frames with DP83867-style indirect extended-register access (REGCR 0x0D / ADDAR 0x0E). The block oversamples MDC/MDIO on the Ethernet clock. It decodes write and read frames addressed to its PHY address and drives read data back on the MDIO tristate. It serves as the far end of the Ethernet MDIO configuration sequencer in system simulation and FPGA loopback, and exposes the three configured extended registers (CFG4, SGMIICTL1, 10M_SGMII_CFG) as outputs.

## Interface
- PHY_ADDR, 5'h03, PHY address this responder answers to
- PHY_ID1, 16'h2000, read-only value of direct register 0x02
- PHY_ID2, 16'hA231, read-only value of direct register 0x03
- PRE_LEN, 32, consecutive preamble ones required before ST (1..32)
- clk_eth_i  input  1  Ethernet clock; one clock; all logic on rising edge
- rst_eth_i  input  1  reset, synchronous, active-high
- mdio_mdc_i  input  1  MDC from master, asynchronous to clk_eth_i
- mdio_mdio_i  input  1  MDIO pad input
- mdio_mdio_o  output  1  MDIO drive value
- mdio_mdio_t  output  1  tristate enable, 1 = released (high-Z), 0 = driving
- busy_o  output  1  high while a frame is being decoded (state != PRE)
- ext_wr_o  output  1  one-cycle pulse on any extended-register write
- ext_addr_o  output  16  extended address of last ext write; valid with ext_wr_o
- cfg4_o  output  16  extended reg 0x0031
- sgmiictl1_o  output  16  extended reg 0x00D3
- sgmii_10m_cfg_o  output  16  extended reg 0x016F

## Operation
- MDC and MDIO are each synchronized with 2 flops. MDC rise/fall are detected from the synchronized value plus one history flop. MDIO is sampled only on detected MDC rise; output changes happen only on detected MDC fall.
- States: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA. Bit counter is 5 bit.
- PRE: 6-bit ones counter, saturating at PRE_LEN, cleared on any sampled 0. A 0 sampled while count == PRE_LEN enters ST. A 0 sampled with count < PRE_LEN stays in PRE.
- ST: the sampled bit must be 1, else return to PRE.
- OP: 2 bits. 01 = write, 10 = read; 00/11 return to PRE.
- PHYAD: 5 bits MSB first. REGAD: 5 bits MSB first. On PHYAD != PHY_ADDR, return to PRE after REGAD completes with no drive and no side effects.
- TA on write: 2 bits ignored, then WDATA 16 bits MSB first. The register update occurs on the cycle after the 16th data rise.
- TA on read: the first TA bit is not driven. On the MDC fall following the first TA rise, assert mdio_t=0, mdio_o=0. On each subsequent fall, shift out the read word MSB first. On the fall after the 16th data rise, release (mdio_t=1) and return to PRE.
- Read data is latched at the end of REGAD.
- Direct registers: a 32x16 file reset to 0. Writes to 0x02/0x03 are ignored and reads of those registers return the ID parameters.
- 0x0D REGCR is stored as written; function = bits[15:14], DEVAD = bits[4:0].
- 0x0E ADDAR:
  - function 00: write latches ext address; read returns it.
  - any other function: write stores data to the ext register at the ext address and pulses ext_wr_o; read returns that register. No post-increment.
- Ext access with DEVAD != 0x1F: writes ignored, reads return 0.
- Ext registers: only 0x0031, 0x00D3 and 0x016F are implemented, reset to 0. Other addresses read 0; writes to them are ignored but still pulse ext_wr_o.
- Frame abort: a detected MDC gap is not tracked. Framing errors only occur via ST/OP checks. The preamble requirement resynchronizes.

## Timing
- Reset values: mdio_mdio_t=1, mdio_mdio_o=1, busy_o=0, ext_wr_o=0, ext_addr_o=0, all ext/direct regs 0, state PRE, counters 0.
- Reset asserted mid-frame releases MDIO on the next clock edge and discards the partial frame. Decoding resumes with a fresh preamble.
- Sampling is 2 sync + 1 edge flop, so MDIO is captured 3 clk after the MDC pin rise. mdio_o/t change 3 clk after the MDC pin fall (registered outputs).
- MDC high and low phases must each be ≥4 clk_eth_i cycles (master prescale 3 gives exactly 4).
- ext_wr_o is high for exactly 1 clk; cfg*/ext_addr_o update in the same cycle.
- Back-to-back frames with a full preamble are all accepted.
- A write immediately followed by a read of the same register returns the new value.

## Test plan
- Reset: assert rst_eth_i 2 clk → mdio_t=1, mdio_o=1, busy_o=0, cfg4_o=sgmiictl1_o=sgmii_10m_cfg_o=0.
- Master writes 0x0D=0x001F, 0x0E=0x0031, 0x0D=0x401F, 0x0E=0x0070 to PHY 3 → cfg4_o=0x0070, exactly one ext_wr_o pulse with ext_addr_o=0x0031. Repeat for 0x00D3=0x4000 and 0x016F=0x0015.
- Read reg 0x02 at PHY 3 → MDIO driven 0 in the second TA bit, then 0x2000 MSB first, then released; master data_out=0x2000.
- Write 0x1234 to reg 0x05 at PHY 5 → mdio_t stays 1, reg 0x05 remains 0 on a PHY 3 readback.
- Preamble of 31 ones followed by a valid write (PRE_LEN=32) → ignored, no register change. Same frame with 32 ones → accepted.
- Assert reset during RDATA bit 8 → mdio_t=1 next clk. The following full read of 0x03 returns 0xA231.
